// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the 16-bit divider and its BCD result stage.
//   div_state_e : IDLE / SHIFT / DONE states of the BCD conversion sequencer
//   DIV_WIDTH   : binary width of the divider quotient/remainder
//   BCD_DIGITS  : number of BCD digits needed to show a DIV_WIDTH-bit value
//   add3        : double-dabble digit adjust (add 3 to a digit of 5 or more)
//   pow10       : constant helper used for elaboration-time range checks
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH  = 16;
    localparam int BCD_DIGITS = 5;

    // A digit of 5..9 becomes 8..12 so the following shift carries into the
    // next digit; the result never exceeds 4 bits.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// ---------------------------------------------------------------------------
// bcd_dabble_core
// One channel of a sequential double-dabble binary-to-BCD converter.
// Holds a binary shift register and a BCD accumulator; one bit per shift.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture bin_in and clear the BCD accumulator
//   shift       : perform one adjust-and-shift step
//   bin_in      : binary value to convert
//   bcd_next    : accumulator value after this cycle's operation
//   ndig_next   : significant digit count of bcd_next (1 for zero)
// The "next" outputs let the sequencer capture the final result on the same
// edge as the last shift, so the result is ready on entry to DONE.
// ---------------------------------------------------------------------------
module bcd_dabble_core
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_next,
    output logic [2:0]            ndig_next
);

    logic [WIDTH-1:0]          bin_q,  bin_d;
    logic [4*DIGITS-1:0]       bcd_q,  bcd_d;
    logic [4*DIGITS-1:0]       bcd_adj;
    logic [4*DIGITS+WIDTH-1:0] shifted;

    always_comb begin
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        bcd_adj = '0;
        shifted = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
        shifted = {bcd_adj, bin_q} << 1;
        if (load) begin
            bin_d = bin_in;
            bcd_d = '0;
        end else if (shift) begin
            bin_d = shifted[WIDTH-1:0];
            bcd_d = shifted[4*DIGITS+WIDTH-1:WIDTH];
        end
    end

    // Highest nonzero digit index + 1; an all-zero value still shows one digit.
    always_comb begin
        ndig_next = 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] != 4'd0) begin
                ndig_next = 3'(i + 1);
            end
        end
    end

    assign bcd_next = bcd_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

endmodule

// File: rtl/div_result_bcd.sv
// ---------------------------------------------------------------------------
// div_result_bcd
// Converts the divider's quotient and remainder to packed BCD in lock-step,
// one bit per clock, with valid/ready handshakes on input and output.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake (ready only in IDLE)
//   quotient, remainder   : binary inputs, WIDTH bits
//   out_valid / out_ready : output handshake (valid only in DONE)
//   q_bcd, r_bcd          : packed BCD results, digit 0 in [3:0]
//   q_ndig, r_ndig        : significant digit counts, 1..DIGITS
// Results are registered on entry to DONE and held until the next result.
// ---------------------------------------------------------------------------
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic [2:0]            q_ndig,
    output logic [2:0]            r_ndig
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    // The largest binary input must be representable in DIGITS digits, and
    // the digit count must fit the 3-bit ndig outputs.
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_small
        $error("div_result_bcd: DIGITS too small for WIDTH");
    end
    if (DIGITS > 7) begin : g_digits_too_large
        $error("div_result_bcd: DIGITS exceeds ndig range");
    end

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   q_bcd_q, q_bcd_d;
    logic [4*DIGITS-1:0]   r_bcd_q, r_bcd_d;
    logic [2:0]            q_ndig_q, q_ndig_d;
    logic [2:0]            r_ndig_q, r_ndig_d;

    logic                  load;
    logic                  shift;
    logic                  last_shift;
    logic [4*DIGITS-1:0]   q_bcd_next, r_bcd_next;
    logic [2:0]            q_ndig_next, r_ndig_next;

    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns through IDLE before a new accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            SHIFT:   shift     = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Bit counter and result capture on the final shift
    always_comb begin
        cnt_d    = cnt_q;
        q_bcd_d  = q_bcd_q;
        r_bcd_d  = r_bcd_q;
        q_ndig_d = q_ndig_q;
        r_ndig_d = r_ndig_q;
        if (load) begin
            cnt_d = '0;
        end else if (shift) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_shift) begin
            q_bcd_d  = q_bcd_next;
            r_bcd_d  = r_bcd_next;
            q_ndig_d = q_ndig_next;
            r_ndig_d = r_ndig_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            q_bcd_q  <= '0;
            r_bcd_q  <= '0;
            q_ndig_q <= 3'd1;
            r_ndig_q <= 3'd1;
        end else begin
            cnt_q    <= cnt_d;
            q_bcd_q  <= q_bcd_d;
            r_bcd_q  <= r_bcd_d;
            q_ndig_q <= q_ndig_d;
            r_ndig_q <= r_ndig_d;
        end
    end

    bcd_dabble_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_q_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .bin_in    (quotient),
        .bcd_next  (q_bcd_next),
        .ndig_next (q_ndig_next)
    );

    bcd_dabble_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_r_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .bin_in    (remainder),
        .bcd_next  (r_bcd_next),
        .ndig_next (r_ndig_next)
    );

    assign q_bcd  = q_bcd_q;
    assign r_bcd  = r_bcd_q;
    assign q_ndig = q_ndig_q;
    assign r_ndig = r_ndig_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// ---------------------------------------------------------------------------
// tb_div_result_bcd
// Drives directed and random quotient/remainder pairs into div_result_bcd.
// Accepted inputs push their expected BCD results into a queue; a monitor
// pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_div_result_bcd;

    typedef struct {
        logic [19:0] q_bcd;
        logic [19:0] r_bcd;
        logic [2:0]  q_ndig;
        logic [2:0]  r_ndig;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] q_bcd;
    logic [19:0] r_bcd;
    logic [2:0]  q_ndig;
    logic [2:0]  r_ndig;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   stream_done;

    div_result_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .q_ndig    (q_ndig),
        .r_ndig    (r_ndig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Reference model: decimal text via $sformat, then digit characters to BCD
    task automatic refBcd(input logic [15:0] v, output logic [19:0] bcd, output logic [2:0] nd);
        string s;
        $sformat(s, "%05d", v);
        bcd = '0;
        nd  = 3'd1;
        for (int i = 0; i < 5; i++) begin
            bcd[4*i +: 4] = 4'(s.getc(4 - i) - 8'd48);
            if (bcd[4*i +: 4] != 4'd0) nd = 3'(i + 1);
        end
    endtask

    // Scoreboard monitor: one pop per output handshake
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got q_bcd=%h, expected no output", q_bcd);
        end else begin
            e = sb.pop_front();
            checkValue("q_bcd",  32'(q_bcd),  32'(e.q_bcd));
            checkValue("r_bcd",  32'(r_bcd),  32'(e.r_bcd));
            checkValue("q_ndig", 32'(q_ndig), 32'(e.q_ndig));
            checkValue("r_ndig", 32'(r_ndig), 32'(e.r_ndig));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) checkOutput();
    end

    // Present one pair until accepted; push the expectation on acceptance.
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] q, input logic [15:0] r,
                                 input logic [19:0] eq, input logic [19:0] er,
                                 input logic [2:0] nq, input logic [2:0] nr,
                                 input bit push_exp);
        exp_t e;
        bit   accepted;
        accepted  = 1'b0;
        in_valid  = 1'b1;
        quotient  = q;
        remainder = r;
        for (int k = 0; k < 300 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (push_exp) begin
                    e.q_bcd = eq; e.r_bcd = er; e.q_ndig = nq; e.r_ndig = nr;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) failNow("accept");
    endtask

    task automatic applyRef(input logic [15:0] q, input logic [15:0] r);
        logic [19:0] eq, er;
        logic [2:0]  nq, nr;
        refBcd(q, eq, nq);
        refBcd(r, er, nr);
        applyStimulus(q, r, eq, er, nq, nr, 1'b1);
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready && (sb.size() == 0);
        end
        if (!ok) failNow("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        bit seen;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        quotient    = '0;
        remainder   = '0;
        out_ready   = 1'b1;
        stream_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkValue("rst_in_ready",  32'(in_ready),  32'd1);
        checkValue("rst_out_valid", 32'(out_valid), 32'd0);
        checkValue("rst_q_bcd",     32'(q_bcd),     32'd0);
        checkValue("rst_r_bcd",     32'(r_bcd),     32'd0);
        checkValue("rst_q_ndig",    32'(q_ndig),    32'd1);
        checkValue("rst_r_ndig",    32'(r_ndig),    32'd1);
        @(posedge clk);
        #1;

        // 1234 / 7 and accept-to-valid latency
        applyStimulus(16'h04D2, 16'h0007, 20'h01234, 20'h00007, 3'd4, 3'd1, 1'b1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        checkValue("latency", 32'(lat), 32'd16);
        waitIdle();

        // Full-scale quotient
        applyStimulus(16'hFFFF, 16'h00FE, 20'h65535, 20'h00254, 3'd5, 3'd3, 1'b1);
        waitIdle();

        // Zero and digit-adjust boundaries
        applyStimulus(16'h0000, 16'h0000, 20'h00000, 20'h00000, 3'd1, 3'd1, 1'b1);
        applyStimulus(16'h0009, 16'h000A, 20'h00009, 20'h00010, 3'd1, 3'd2, 1'b1);
        applyStimulus(16'h000A, 16'h0009, 20'h00010, 20'h00009, 3'd2, 3'd1, 1'b1);
        waitIdle();

        // Backpressure: hold 10 cycles in DONE with a competing in_valid
        out_ready = 1'b0;
        applyStimulus(16'h0457, 16'h0063, 20'h01111, 20'h00099, 3'd4, 3'd2, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) failNow("bp_valid");
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        quotient  = 16'h2222;
        remainder = 16'h3333;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkValue("bp_out_valid", 32'(out_valid), 32'd1);
            checkValue("bp_q_bcd",     32'(q_bcd),     32'h01111);
            checkValue("bp_r_bcd",     32'(r_bcd),     32'h00099);
            checkValue("bp_in_ready",  32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkValue("bp_ready_after", 32'(in_ready),  32'd1);
        checkValue("bp_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset during the 8th shift cycle discards the conversion
        applyStimulus(16'h0123, 16'h0045, 20'h0, 20'h0, 3'd1, 3'd1, 1'b0);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkValue("abort_out_valid", 32'(out_valid), 32'd0);
        checkValue("abort_in_ready",  32'(in_ready),  32'd1);
        checkValue("abort_q_bcd",     32'(q_bcd),     32'd0);
        @(posedge clk);
        #1;
        applyStimulus(16'h0064, 16'h0000, 20'h00100, 20'h00000, 3'd3, 3'd1, 1'b1);
        waitIdle();

        // Random stream with random gaps and random backpressure
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    applyRef(16'($urandom), 16'($urandom));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        waitIdle();
        checkValue("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
